// File: rtl/bus_cycle_sequencer_pkg.sv
// Shared constants and FSM encoding for the chip-bus cycle sequencer.
package bus_cycle_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHIP   = 2'd1,
    ST_E_WAIT = 2'd2,
    ST_VMA    = 2'd3
  } seq_state_e;

  localparam int E_PERIOD        = 10;
  localparam int E_HIGH_START    = 6;
  localparam int E_VMA_SLOT      = 2;
  localparam int DMA_RUN_MAX_DEF = 3;
endpackage

// File: rtl/bus_cycle_sequencer_eclk_divider.sv
// 28 MHz -> 7 MHz slot phase counter and the 10-slot E clock divider.
module eclk_divider
  import bus_cycle_sequencer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [1:0] o_phase,
  output logic [3:0] o_ediv,
  output logic       o_clk7_en,
  output logic       o_eclk,
  output logic       o_e_pulse
);
  localparam logic [3:0] EDIV_LAST = 4'(E_PERIOD - 1);

  logic [1:0] r_phase;
  logic [3:0] r_ediv;
  logic       w_clk7_en;

  assign w_clk7_en = (r_phase == 2'd3);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
      r_ediv  <= '0;
    end else begin
      r_phase <= r_phase + 2'd1;
      if (w_clk7_en) r_ediv <= (r_ediv == EDIV_LAST) ? 4'd0 : r_ediv + 4'd1;
    end
  end

  // Decoded straight from reset-cleared registers, so they drop with reset.
  assign o_phase   = r_phase;
  assign o_ediv    = r_ediv;
  assign o_clk7_en = w_clk7_en;
  assign o_eclk    = (r_ediv >= 4'(E_HIGH_START));
  assign o_e_pulse = w_clk7_en && (r_ediv == EDIV_LAST);
endmodule

// File: rtl/bus_cycle_sequencer.sv
// Chip-slot arbiter (DMA vs CPU) and CPU cycle FSM for chip and 6800-style cycles.
module bus_cycle_sequencer
  import bus_cycle_sequencer_pkg::*;
#(
  parameter int DMA_RUN_MAX = DMA_RUN_MAX_DEF
) (
  input  logic       clk28m,
  input  logic       _reset,
  input  logic       cpu_req,
  input  logic       cpu_vpa,
  input  logic       dma_req,
  output logic [1:0] phase,
  output logic       clk7_en,
  output logic       eclk,
  output logic       e_pulse,
  output logic       dma_grant,
  output logic       cpu_grant,
  output logic       vma,
  output logic       cpu_ack
);
  localparam int RUN_W = $clog2(DMA_RUN_MAX + 1);

  logic [1:0]       w_phase;
  logic [3:0]       w_ediv;
  logic             w_clk7_en, w_eclk, w_e_pulse;
  seq_state_e       r_state;
  logic             r_dma_grant, r_cpu_grant, r_slot_valid;
  logic             r_vma, r_ack, r_wait_low;
  logic [RUN_W-1:0] r_dma_run;
  logic             w_cpu_pend, w_run_open, w_dma_win, w_cpu_win;

  eclk_divider u_ediv (
    .i_clk     (clk28m),
    .i_rst_n   (_reset),
    .o_phase   (w_phase),
    .o_ediv    (w_ediv),
    .o_clk7_en (w_clk7_en),
    .o_eclk    (w_eclk),
    .o_e_pulse (w_e_pulse)
  );

  // A chip request stops being pending once its ack is out.
  assign w_cpu_pend = (r_state == ST_CHIP) && cpu_req && !r_ack;
  assign w_run_open = (r_dma_run < RUN_W'(DMA_RUN_MAX));
  assign w_dma_win  = dma_req && (w_run_open || !w_cpu_pend);
  assign w_cpu_win  = !w_dma_win && w_cpu_pend;

  always_ff @(posedge clk28m or negedge _reset) begin
    if (!_reset) begin
      r_state      <= ST_IDLE;
      r_dma_grant  <= 1'b0;
      r_cpu_grant  <= 1'b0;
      r_slot_valid <= 1'b0;
      r_vma        <= 1'b0;
      r_ack        <= 1'b0;
      r_wait_low   <= 1'b0;
      r_dma_run    <= '0;
    end else begin
      if (!cpu_req) r_wait_low <= 1'b0;
      if (w_clk7_en) begin
        r_dma_grant  <= w_dma_win;
        r_cpu_grant  <= w_cpu_win;
        r_slot_valid <= w_cpu_win;
        if (w_cpu_win || !w_cpu_pend) r_dma_run <= '0;
        else if (w_dma_win && w_run_open) r_dma_run <= r_dma_run + RUN_W'(1);
      end
      unique case (r_state)
        ST_IDLE: begin
          if (cpu_req && !r_wait_low) r_state <= cpu_vpa ? ST_E_WAIT : ST_CHIP;
        end
        ST_CHIP: begin
          // A withdrawn request keeps its slot on the bus but never sees an ack.
          if (!cpu_req || r_ack) begin
            r_state      <= ST_IDLE;
            r_ack        <= 1'b0;
            r_slot_valid <= 1'b0;
            r_wait_low   <= r_ack && cpu_req;
          end else if (r_slot_valid && w_phase == 2'd2) begin
            r_ack <= 1'b1;
          end
        end
        ST_E_WAIT: begin
          if (!cpu_req) r_state <= ST_IDLE;
          else if (w_clk7_en && w_ediv == 4'(E_VMA_SLOT)) begin
            r_state <= ST_VMA;
            r_vma   <= 1'b1;
          end
        end
        ST_VMA: begin
          if (!cpu_req || r_ack) begin
            r_state    <= ST_IDLE;
            r_vma      <= 1'b0;
            r_ack      <= 1'b0;
            r_wait_low <= r_ack && cpu_req;
          end else if (w_phase == 2'd2 && w_ediv == 4'(E_PERIOD - 1)) begin
            r_ack <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign phase     = w_phase;
  assign clk7_en   = w_clk7_en;
  assign eclk      = w_eclk;
  assign e_pulse   = w_e_pulse;
  assign dma_grant = r_dma_grant;
  assign cpu_grant = r_cpu_grant;
  assign vma       = r_vma;
  assign cpu_ack   = r_ack;
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer; cyc is a free-running model of clk28m edges since reset.
`timescale 1ns/1ps
module tb_bus_cycle_sequencer;
  logic       clk28m = 1'b0, _reset = 1'b0;
  logic       cpu_req = 1'b0, cpu_vpa = 1'b0, dma_req = 1'b0;
  logic [1:0] phase;
  logic       clk7_en, eclk, e_pulse, dma_grant, cpu_grant, vma, cpu_ack;
  int         cyc;
  int         n_vec = 0, n_err = 0;
  logic       dv[64], cv[64], av[64], vv[64], ev[64];

  bus_cycle_sequencer #(.DMA_RUN_MAX(3)) dut (
    .clk28m(clk28m), ._reset(_reset), .cpu_req(cpu_req), .cpu_vpa(cpu_vpa),
    .dma_req(dma_req), .phase(phase), .clk7_en(clk7_en), .eclk(eclk),
    .e_pulse(e_pulse), .dma_grant(dma_grant), .cpu_grant(cpu_grant),
    .vma(vma), .cpu_ack(cpu_ack)
  );

  always #5 clk28m = ~clk28m;

  always @(posedge clk28m or negedge _reset)
    if (!_reset) cyc <= 0; else cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk28m);
  endtask

  task automatic align(input int m, input int v);
    int k;
    k = 0;
    while ((cyc % m) != v && k < 200) begin step(); k++; end
    chk("align", 32'((cyc % m) == v), 1);
  endtask

  task automatic capture(input int j);
    dv[j] = dma_grant; cv[j] = cpu_grant; av[j] = cpu_ack; vv[j] = vma; ev[j] = e_pulse;
  endtask

  function automatic logic [9:0] all_outs();
    return {phase, clk7_en, eclk, e_pulse, dma_grant, cpu_grant, vma, cpu_ack};
  endfunction

  initial begin
    int c7, eh, ep, gr, both, acks, fv, aat, got;
    repeat (3) step();
    chk("rst_outputs", 32'(all_outs()), 0);
    _reset = 1'b1;

    // Free run with no requests
    c7 = 0; eh = 0; ep = 0; gr = 0;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (k == 1) chk("first_phase", 32'(phase), 1);
      c7 += int'(clk7_en); eh += int'(eclk); ep += int'(e_pulse);
      gr += int'(dma_grant | cpu_grant);
    end
    chk("clk7_cnt", c7, 20);
    chk("eclk_cnt", eh, 32);
    chk("epulse_cnt", ep, 2);
    chk("idle_grants", gr, 0);

    // DMA run limit: three DMA slots, then the CPU slot, then DMA again
    dma_req = 1'b1;
    repeat (4) step();
    align(4, 0);
    for (int j = 0; j < 24; j++) begin
      if (j > 0) step();
      capture(j);
      if (j == 0) cpu_req = 1'b1;
      if (av[j]) cpu_req = 1'b0;
    end
    both = 0; acks = 0;
    for (int j = 0; j < 24; j++) begin both += int'(dv[j] & cv[j]); acks += int'(av[j]); end
    chk("dma_slot0", 32'(dv[1]), 1);
    chk("dma_slot1", 32'(dv[5]), 1);
    chk("dma_slot2", 32'(dv[9]), 1);
    chk("dma_slot3", 32'(dv[13]), 1);
    chk("cpu_pre", 32'(cv[15]), 0);
    chk("cpu_slot_ph0", 32'(cv[16]), 1);
    chk("cpu_slot_nodma", 32'(dv[17]), 0);
    chk("chip_ack_ph3", 32'(av[19]), 1);
    chk("chip_ack_cnt", acks, 1);
    chk("dma_resume", 32'(dv[21]), 1);
    chk("grant_excl", both, 0);
    dma_req = 1'b0;

    // 6800 cycle requested at ediv=5; vpa wiggle mid-cycle ignored
    align(40, 20);
    fv = -1; aat = -1; acks = 0;
    for (int j = 0; j < 64; j++) begin
      if (j > 0) step();
      capture(j);
      if (j == 0) begin cpu_req = 1'b1; cpu_vpa = 1'b1; end
      if (j == 10) cpu_vpa = 1'b0;
      if (vv[j] && fv < 0) fv = j;
      if (av[j]) begin acks++; if (aat < 0) aat = j; cpu_req = 1'b0; end
    end
    chk("vma_rise", fv, 32);
    chk("vpa_ack_at", aat, 59);
    chk("vpa_ack_epulse", 32'(ev[59]), 1);
    chk("vma_at_ack", 32'(vv[59]), 1);
    chk("vma_fall", 32'(vv[60]), 0);
    chk("vpa_ack_cnt", acks, 1);

    // 6800 cycle withdrawn at ediv=7
    align(40, 0);
    acks = 0;
    for (int j = 0; j < 48; j++) begin
      if (j > 0) step();
      capture(j);
      if (j == 0) begin cpu_req = 1'b1; cpu_vpa = 1'b1; end
      if (j == 28) cpu_req = 1'b0;
      acks += int'(av[j]);
    end
    cpu_vpa = 1'b0;
    chk("wd_vma_pre", 32'(vv[11]), 0);
    chk("wd_vma_on", 32'(vv[12]), 1);
    chk("wd_vma_held", 32'(vv[28]), 1);
    chk("wd_vma_off", 32'(vv[29]), 0);
    chk("wd_no_ack", acks, 0);

    // Back-to-back chip cycles, no DMA
    both = 0;
    for (int r = 0; r < 3; r++) begin
      cpu_req = 1'b1; got = 0;
      for (int k = 0; k < 24 && got == 0; k++) begin
        step();
        both += int'(dma_grant & cpu_grant);
        if (cpu_ack) got = 1;
      end
      chk($sformatf("b2b_ack%0d", r), got, 1);
      if (r < 2) begin cpu_req = 1'b0; step(); chk("b2b_pulse", 32'(cpu_ack), 0); end
    end
    acks = 0;
    for (int k = 0; k < 20; k++) begin step(); acks += int'(cpu_ack); end
    chk("hold_no_reack", acks, 0);
    cpu_req = 1'b0;
    chk("b2b_excl", both, 0);

    // Asynchronous reset in the middle of a CPU slot
    step();
    cpu_req = 1'b1; got = 0;
    for (int k = 0; k < 24 && got == 0; k++) begin step(); if (cpu_grant) got = 1; end
    chk("pre_rst_grant", got, 1);
    #2 _reset = 1'b0; cpu_req = 1'b0;
    #1 chk("rst_async_outs", 32'(all_outs()), 0);
    step();
    _reset = 1'b1;
    ep = -1; acks = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) chk("rst_phase_restart", 32'(phase), 1);
      if (e_pulse && ep < 0) ep = k;
      acks += int'(cpu_ack);
    end
    chk("rst_ediv_restart", ep, 39);
    chk("rst_no_ack", acks, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
